dispatch_rr: RTL and testbench



---
 rtl/dispatch_pkg.sv | 20 ++
 rtl/dispatch_rr_arbiter.sv | 30 +++
 rtl/dispatch_rr.sv | 175 +++++++++++++++++
 tb/tb_dispatch_rr.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the round-robin kernel block dispatcher.
package dispatch_pkg;

  typedef enum logic [2:0] {StIdle, StPrime, StDispatch, StDrain, StDone} state_e;
  typedef enum logic [1:0] {CoreFree, CoreRun, CoreRecycle} core_state_e;

  localparam int unsigned MaxCores = 16;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 32'd1) / den;
  endfunction

  function automatic int unsigned popcount(input logic [MaxCores-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxCores; i++) cnt += 32'(vec[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/dispatch_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IdxW-1:0]      ptr,
  output logic [NUM_CORES-1:0] gnt,
  output logic [IdxW-1:0]      gnt_idx,
  output logic                 valid
);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < NUM_CORES; off++) begin
      idx = IdxW'((32'(ptr) + off) % NUM_CORES);
      if (!valid && req[idx]) begin
        valid   = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt[gnt_idx] = valid;
  end

endmodule

// File: rtl/dispatch_rr.sv
// Splits a kernel into fixed-size thread blocks and hands them to cores round-robin.
module dispatch_rr
  import dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned THREAD_COUNT_W    = 8,
  parameter int unsigned BLOCK_ID_W        = 8,
  localparam int unsigned TC_W             = $clog2(THREADS_PER_BLOCK + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [THREAD_COUNT_W-1:0]        thread_count,
  input  logic [NUM_CORES-1:0]             core_done,
  output logic [NUM_CORES-1:0]             core_start,
  output logic [NUM_CORES-1:0]             core_reset,
  output logic [NUM_CORES*BLOCK_ID_W-1:0]  core_block_id,
  output logic [NUM_CORES*TC_W-1:0]        core_thread_count,
  output logic [BLOCK_ID_W-1:0]            blocks_done,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                          state_q, state_d;
  core_state_e                     core_st_q [NUM_CORES];
  core_state_e                     core_st_d [NUM_CORES];
  logic [THREAD_COUNT_W-1:0]       tc_q, tc_d;
  logic [BLOCK_ID_W-1:0]           disp_q, disp_d, done_cnt_q, done_cnt_d, total_blocks;
  logic [IdxW-1:0]                 rr_q, rr_d, gnt_idx;
  logic [NUM_CORES-1:0]            start_q, start_d, creset_q, creset_d, req, comp, gnt;
  logic [NUM_CORES*BLOCK_ID_W-1:0] bid_q, bid_d;
  logic [NUM_CORES*TC_W-1:0]       ctc_q, ctc_d;
  logic                            aborted_q, aborted_d, gnt_valid;
  logic [31:0]                     remaining;
  logic [TC_W-1:0]                 blk_threads;

  assign total_blocks = BLOCK_ID_W'(ceil_div(32'(tc_q), THREADS_PER_BLOCK));
  // Only the final block can be short; every earlier one is full.
  assign remaining    = 32'(tc_q) - 32'(disp_q) * THREADS_PER_BLOCK;
  assign blk_threads  = (remaining >= THREADS_PER_BLOCK) ? TC_W'(THREADS_PER_BLOCK)
                                                         : TC_W'(remaining);

  always_comb begin
    req  = '0;
    comp = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req[i]  = (core_st_q[i] == CoreFree);
      comp[i] = (core_st_q[i] == CoreRun) && core_done[i];
    end
  end

  rr_arbiter #(
    .NUM_CORES(NUM_CORES)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (rr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .valid  (gnt_valid)
  );

  always_comb begin
    state_d    = state_q;
    tc_d       = tc_q;
    disp_d     = disp_q;
    done_cnt_d = done_cnt_q;
    rr_d       = rr_q;
    start_d    = start_q;
    creset_d   = '0;
    bid_d      = bid_q;
    ctc_d      = ctc_q;
    aborted_d  = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_st_d[i] = (core_st_q[i] == CoreRecycle) ? CoreFree : core_st_q[i];
    end

    if (abort && state_q != StIdle) begin
      state_d   = StIdle;
      start_d   = '0;
      creset_d  = '1;
      aborted_d = 1'b1;
      for (int i = 0; i < NUM_CORES; i++) core_st_d[i] = CoreFree;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            tc_d       = thread_count;
            disp_d     = '0;
            done_cnt_d = '0;
            creset_d   = '1;
            state_d    = StPrime;
          end
        end
        StPrime: begin
          start_d = '0;
          for (int i = 0; i < NUM_CORES; i++) core_st_d[i] = CoreFree;
          state_d = (total_blocks == '0) ? StDone : StDispatch;
        end
        StDispatch, StDrain: begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (comp[i]) begin
              start_d[i]   = 1'b0;
              creset_d[i]  = 1'b1;
              core_st_d[i] = CoreRecycle;
            end
          end
          done_cnt_d = done_cnt_q + BLOCK_ID_W'(popcount(MaxCores'(comp)));
          if (state_q == StDispatch && gnt_valid) begin
            for (int i = 0; i < NUM_CORES; i++) begin
              if (gnt[i]) begin
                start_d[i]                          = 1'b1;
                bid_d[i*BLOCK_ID_W +: BLOCK_ID_W]   = disp_q;
                ctc_d[i*TC_W +: TC_W]               = blk_threads;
                core_st_d[i]                        = CoreRun;
              end
            end
            rr_d   = IdxW'((32'(gnt_idx) + 32'd1) % NUM_CORES);
            disp_d = disp_q + BLOCK_ID_W'(1);
            if (disp_d == total_blocks) state_d = StDrain;
          end
          if (state_q == StDrain && done_cnt_q == total_blocks) state_d = StDone;
        end
        StDone: begin
          start_d = '0;
          if (!start) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      tc_q       <= '0;
      disp_q     <= '0;
      done_cnt_q <= '0;
      rr_q       <= '0;
      start_q    <= '0;
      creset_q   <= '1;
      bid_q      <= '0;
      ctc_q      <= '0;
      aborted_q  <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) core_st_q[i] <= CoreFree;
    end else begin
      state_q    <= state_d;
      tc_q       <= tc_d;
      disp_q     <= disp_d;
      done_cnt_q <= done_cnt_d;
      rr_q       <= rr_d;
      start_q    <= start_d;
      creset_q   <= creset_d;
      bid_q      <= bid_d;
      ctc_q      <= ctc_d;
      aborted_q  <= aborted_d;
      for (int i = 0; i < NUM_CORES; i++) core_st_q[i] <= core_st_d[i];
    end
  end

  assign core_start        = start_q;
  assign core_reset        = creset_q;
  assign core_block_id     = bid_q;
  assign core_thread_count = ctc_q;
  assign blocks_done       = done_cnt_q;
  assign aborted           = aborted_q;
  assign busy              = (state_q == StPrime) || (state_q == StDispatch) ||
                             (state_q == StDrain);
  assign done              = (state_q == StDone);

endmodule

// File: tb/tb_dispatch_rr.sv
// Directed bench: 2-core dispatcher with a behavioural core model, plus a 4-core instance.
module tb_dispatch_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: 2 cores, 4 threads per block
  logic        a_start, a_abort;
  logic [7:0]  a_tc;
  logic [1:0]  a_core_done = '0;
  logic [1:0]  a_core_start, a_core_reset;
  logic [15:0] a_bid;
  logic [5:0]  a_ctc;
  logic [7:0]  a_bd;
  logic        a_busy, a_done, a_aborted;

  // Instance B: 4 cores whose blocks never complete
  logic        b_start, b_abort;
  logic [7:0]  b_tc;
  logic [3:0]  b_core_done;
  logic [3:0]  b_core_start, b_core_reset;
  logic [31:0] b_bid;
  logic [11:0] b_ctc;
  logic [7:0]  b_bd;
  logic        b_busy, b_done, b_aborted;

  dispatch_rr #(.NUM_CORES(2), .THREADS_PER_BLOCK(4), .THREAD_COUNT_W(8), .BLOCK_ID_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort), .thread_count(a_tc),
    .core_done(a_core_done), .core_start(a_core_start), .core_reset(a_core_reset),
    .core_block_id(a_bid), .core_thread_count(a_ctc), .blocks_done(a_bd),
    .busy(a_busy), .done(a_done), .aborted(a_aborted)
  );

  dispatch_rr #(.NUM_CORES(4), .THREADS_PER_BLOCK(4), .THREAD_COUNT_W(8), .BLOCK_ID_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .thread_count(b_tc),
    .core_done(b_core_done), .core_start(b_core_start), .core_reset(b_core_reset),
    .core_block_id(b_bid), .core_thread_count(b_ctc), .blocks_done(b_bd),
    .busy(b_busy), .done(b_done), .aborted(b_aborted)
  );

  // Core model: raises core_done lat[i] cycles after core_start rises, drops it when start falls.
  int lat [2];
  int cnt [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!a_core_start[i] || a_core_reset[i]) begin
        cnt[i] = 0;
        a_core_done[i] = 1'b0;
      end else if (!a_core_done[i]) begin
        cnt[i] = cnt[i] + 1;
        if (cnt[i] >= lat[i]) a_core_done[i] = 1'b1;
      end
    end
  end

  // Grant log (edge index relative to launch) and core_reset pulse-width tracking
  logic [1:0] prev_start = '0;
  int n_grants = 0;
  int base_cyc = 0;
  int g_core [16];
  int g_id [16];
  int g_tc [16];
  int g_rel [16];
  int rst_run [2];
  int max_rst_run = 0;
  bit mon_en = 1'b0;
  int bd_trace [64];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (a_core_start[i] && !prev_start[i] && n_grants < 16) begin
        g_core[n_grants] = i;
        g_id[n_grants]   = int'(a_bid[i*8 +: 8]);
        g_tc[n_grants]   = int'(a_ctc[i*3 +: 3]);
        g_rel[n_grants]  = cyc - base_cyc - 1;
        n_grants = n_grants + 1;
      end
      if (a_core_reset[i]) rst_run[i] = rst_run[i] + 1;
      else rst_run[i] = 0;
      if (mon_en && rst_run[i] > max_rst_run) max_rst_run = rst_run[i];
    end
    prev_start = a_core_start;
  end

  task automatic launch_a(input logic [7:0] tc, input int bound, output int k);
    n_grants = 0;
    base_cyc = cyc;
    a_tc = tc;
    a_start = 1'b1;
    k = 0;
    while (!a_done && k < bound) begin
      @(negedge clk);
      k++;
      bd_trace[k] = int'(a_bd);
    end
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL launch_timeout tc=%0d got done=%b exp done=1", tc, a_done);
    end
  endtask

  task automatic finish_a();
    a_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_core_start !== 2'b00 || a_core_reset !== 2'b11) begin
      failures++;
      $display("FAIL reset_core got start=%b rst=%b exp start=00 rst=11", a_core_start, a_core_reset);
    end
    checks++;
    if (a_bid !== 16'h0 || a_ctc !== 6'h0 || a_bd !== 8'h0) begin
      failures++;
      $display("FAIL reset_fields got bid=%h ctc=%h bd=%h exp 0", a_bid, a_ctc, a_bd);
    end
    checks++;
    if ({a_busy, a_done, a_aborted} !== 3'b000 || b_core_reset !== 4'hf) begin
      failures++;
      $display("FAIL reset_status got bda=%b brst=%b exp 000 f", {a_busy, a_done, a_aborted},
               b_core_reset);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (a_core_reset !== 2'b00) begin
      failures++;
      $display("FAIL reset_release got rst=%b exp 00", a_core_reset);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int k;
    int ec [2] = '{0, 1};
    int er [2] = '{2, 3};
    lat[0] = 3; lat[1] = 3;
    launch_a(8'd8, 40, k);
    checks++;
    if (k !== 8 || a_bd !== 8'd2 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got k=%0d bd=%0d busy=%b exp k=8 bd=2 busy=0", k, a_bd, a_busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || n_grants !== 2) begin
      failures++;
      $display("FAIL basic_hold got done=%b grants=%0d exp done=1 grants=2", a_done, n_grants);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (g_core[i] !== ec[i] || g_id[i] !== i || g_tc[i] !== 4 || g_rel[i] !== er[i]) begin
        failures++;
        $display("FAIL basic_grant%0d got core=%0d id=%0d tc=%0d rel=%0d exp core=%0d id=%0d tc=4 rel=%0d",
                 i, g_core[i], g_id[i], g_tc[i], g_rel[i], ec[i], i, er[i]);
      end
    end
    a_start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got done=%b busy=%b exp done=0 busy=0", a_done, a_busy);
    end
  endtask

  task automatic test_partial_block();
    logic [3:0] st [7];
    b_tc = 8'd10;
    b_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      st[k] = b_core_start;
    end
    b_start = 1'b0;
    checks++;
    if (st[2] !== 4'b0000 || st[3] !== 4'b0001 || st[4] !== 4'b0011 || st[5] !== 4'b0111) begin
      failures++;
      $display("FAIL partial_seq got %b %b %b %b exp 0000 0001 0011 0111", st[2], st[3], st[4], st[5]);
    end
    checks++;
    if (st[6] !== 4'b0111 || b_busy !== 1'b1) begin
      failures++;
      $display("FAIL partial_core3 got start=%b busy=%b exp 0111 1", st[6], b_busy);
    end
    checks++;
    if (b_bid[23:0] !== 24'h020100) begin
      failures++;
      $display("FAIL partial_ids got %h exp 020100", b_bid[23:0]);
    end
    checks++;
    if (b_ctc[8:0] !== {3'd2, 3'd4, 3'd4}) begin
      failures++;
      $display("FAIL partial_tc got %o exp 244", b_ctc[8:0]);
    end
  endtask

  task automatic test_fairness();
    int k;
    int ec [5] = '{0, 1, 1, 0, 1};
    int er [5] = '{2, 3, 6, 8, 9};
    lat[0] = 4; lat[1] = 1;
    launch_a(8'd20, 60, k);
    checks++;
    if (k !== 14 || a_bd !== 8'd5) begin
      failures++;
      $display("FAIL fair_done got k=%0d bd=%0d exp k=14 bd=5", k, a_bd);
    end
    finish_a();
    checks++;
    if (n_grants !== 5) begin
      failures++;
      $display("FAIL fair_count got %0d exp 5", n_grants);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (g_core[i] !== ec[i] || g_id[i] !== i || g_tc[i] !== 4 || g_rel[i] !== er[i]) begin
        failures++;
        $display("FAIL fair_grant%0d got core=%0d id=%0d tc=%0d rel=%0d exp core=%0d id=%0d tc=4 rel=%0d",
                 i, g_core[i], g_id[i], g_tc[i], g_rel[i], ec[i], i, er[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int ec [4] = '{0, 1, 0, 1};
    int er [4] = '{2, 3, 7, 8};
    lat[0] = 3; lat[1] = 2;
    launch_a(8'd16, 60, k);
    checks++;
    if (k !== 12 || bd_trace[5] !== 0 || bd_trace[6] !== 2 || a_bd !== 8'd4) begin
      failures++;
      $display("FAIL b2b_count got k=%0d bd5=%0d bd6=%0d bd=%0d exp k=12 0 2 4", k, bd_trace[5],
               bd_trace[6], a_bd);
    end
    finish_a();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g_core[i] !== ec[i] || g_id[i] !== i || g_tc[i] !== 4 || g_rel[i] !== er[i]) begin
        failures++;
        $display("FAIL b2b_grant%0d got core=%0d id=%0d tc=%0d rel=%0d exp core=%0d id=%0d tc=4 rel=%0d",
                 i, g_core[i], g_id[i], g_tc[i], g_rel[i], ec[i], i, er[i]);
      end
    end
  endtask

  task automatic test_zero_threads();
    int k;
    launch_a(8'd0, 10, k);
    checks++;
    if (k !== 2 || a_busy !== 1'b0 || a_bd !== 8'd0) begin
      failures++;
      $display("FAIL zero_done got k=%0d busy=%b bd=%0d exp k=2 busy=0 bd=0", k, a_busy, a_bd);
    end
    finish_a();
    checks++;
    if (n_grants !== 0) begin
      failures++;
      $display("FAIL zero_grants got %0d exp 0", n_grants);
    end
  endtask

  task automatic test_abort();
    int k;
    lat[0] = 30; lat[1] = 30;
    n_grants = 0;
    base_cyc = cyc;
    a_tc = 8'd20;
    a_start = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (a_core_start !== 2'b11 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre got start=%b busy=%b exp 11 1", a_core_start, a_busy);
    end
    a_abort = 1'b1;
    a_start = 1'b0;
    @(negedge clk);
    a_abort = 1'b0;
    checks++;
    if (a_aborted !== 1'b1 || a_core_reset !== 2'b11 || a_core_start !== 2'b00) begin
      failures++;
      $display("FAIL abort_take got ab=%b rst=%b start=%b exp 1 11 00", a_aborted, a_core_reset,
               a_core_start);
    end
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || a_bd !== 8'd0) begin
      failures++;
      $display("FAIL abort_status got done=%b busy=%b bd=%0d exp 0 0 0", a_done, a_busy, a_bd);
    end
    @(negedge clk);
    checks++;
    if (a_aborted !== 1'b0 || a_core_reset !== 2'b00 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse got ab=%b rst=%b done=%b exp 0 00 0", a_aborted, a_core_reset, a_done);
    end
    lat[0] = 2; lat[1] = 2;
    launch_a(8'd4, 30, k);
    checks++;
    if (k !== 6 || a_bd !== 8'd1) begin
      failures++;
      $display("FAIL relaunch_done got k=%0d bd=%0d exp k=6 bd=1", k, a_bd);
    end
    finish_a();
    checks++;
    if (n_grants !== 1 || g_core[0] !== 0 || g_id[0] !== 0 || g_tc[0] !== 4) begin
      failures++;
      $display("FAIL relaunch_grant got n=%0d core=%0d id=%0d tc=%0d exp 1 0 0 4", n_grants,
               g_core[0], g_id[0], g_tc[0]);
    end
  endtask

  initial begin
    reset = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_tc = '0;
    b_start = 1'b0; b_abort = 1'b0; b_tc = '0; b_core_done = '0;
    lat[0] = 1; lat[1] = 1;
    test_reset();
    test_basic();
    test_partial_block();
    test_fairness();
    test_back_to_back();
    test_zero_threads();
    test_abort();
    checks++;
    if (max_rst_run !== 1) begin
      failures++;
      $display("FAIL reset_pulse_width got %0d exp 1", max_rst_run);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
